// File: rtl/arith_op_sequencer_if.sv
// Datapath bus between the sequencer and the external add/subtract datapath.
//   dp_a, dp_b : registered operands driven by the sequencer
//   dp_sub     : 1 = subtract (datapath computes A + ~B + 1)
//   dp_sum     : combinational result from the datapath
//   dp_ovf     : signed overflow flag from the datapath
// master = sequencer side, slave = datapath side.
interface arith_op_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_sub;
  logic [WIDTH-1:0] dp_sum;
  logic             dp_ovf;

  modport master (output dp_a, output dp_b, output dp_sub, input dp_sum, input dp_ovf);
  modport slave  (input dp_a, input dp_b, input dp_sub, output dp_sum, output dp_ovf);
endinterface

// File: rtl/arith_op_sequencer.sv
// arith_op_sequencer: debounces the operator buttons, loads operands from the
// switches, issues add/subtract to the external datapath, captures the result
// and converts its magnitude to 3 BCD digits with a sequential double-dabble.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   dp    datapath bus (master): dp_a, dp_b, dp_sub out; dp_sum, dp_ovf in
//   sw    operand source switches
//   btn   raw buttons: [0] load A, [1] load B, [2] add, [3] subtract
//   bcd   magnitude of last result, hundreds in [11:8]
//   neg   last result negative
//   ovf   last result overflowed
//   busy  high during EXEC and CONV
//   done  one-cycle pulse when bcd/neg/ovf update
//
// Optional build macro RESULT_CHAIN_EN: on completion, dp_a takes the result so
// successive runs chain on the previous result.
module arith_op_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned WIDTH           = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  arith_op_sequencer_if.master        dp,
  input  logic [WIDTH-1:0]            sw,
  input  logic [3:0]                  btn,
  output logic [11:0]                 bcd,
  output logic                        neg,
  output logic                        ovf,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned SCW = $clog2(WIDTH);
  localparam logic [CW-1:0]  DB_MAX    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] STEP_LAST = SCW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;

  state_t state_q, state_d;

  logic [3:0]    sync1, sync2, lvl, pulse;
  logic [CW-1:0] db_cnt [4];

  logic [WIDTH-1:0] mag;
  logic [11:0]      sh;
  logic [11:0]      dd_next;
  logic [SCW-1:0]   step;
  logic             neg_s;
  logic             ovf_s;
`ifdef RESULT_CHAIN_EN
  logic [WIDTH-1:0] raw;
`endif

  logic accept, run, last_step;

  // Synchronizer + debounce: the accepted level flips only after DB_MAX+1
  // consecutive cycles of a differing synchronized level; a rising flip
  // emits a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      pulse <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
          pulse[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign accept    = (state_q == IDLE) || (state_q == DONE);
  assign run       = accept && (pulse[2] || pulse[3]);
  assign last_step = (step == STEP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE, DONE: if (run) state_d = EXEC;
      EXEC: begin
        busy    = 1'b1;
        state_d = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: adjust digits >= 5, then shift in the next mag bit.
  always_comb begin
    logic [11:0] adj;
    adj = sh;
    for (int unsigned d = 0; d < 3; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    dd_next = {adj[10:0], mag[WIDTH-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp.dp_a   <= '0;
      dp.dp_b   <= '0;
      dp.dp_sub <= 1'b0;
      mag       <= '0;
      sh        <= '0;
      step      <= '0;
      neg_s     <= 1'b0;
      ovf_s     <= 1'b0;
      bcd       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
`ifdef RESULT_CHAIN_EN
      raw       <= '0;
`endif
    end else begin
      done <= 1'b0;
      // Loads land on the same edge as the run decision, so EXEC sees them.
      if (accept) begin
        if (pulse[0]) dp.dp_a <= sw;
        if (pulse[1]) dp.dp_b <= sw;
        if (run)      dp.dp_sub <= pulse[3];
      end
      case (state_q)
        EXEC: begin
          neg_s <= dp.dp_sum[WIDTH-1];
          ovf_s <= dp.dp_ovf;
          mag   <= dp.dp_sum[WIDTH-1] ? (~dp.dp_sum + 1'b1) : dp.dp_sum;
          sh    <= '0;
          step  <= '0;
`ifdef RESULT_CHAIN_EN
          raw   <= dp.dp_sum;
`endif
        end
        CONV: begin
          sh   <= dd_next;
          mag  <= {mag[WIDTH-2:0], 1'b0};
          step <= step + 1'b1;
          if (last_step) begin
            bcd  <= dd_next;
            neg  <= neg_s;
            ovf  <= ovf_s;
            done <= 1'b1;
`ifdef RESULT_CHAIN_EN
            dp.dp_a <= raw;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_op_sequencer.sv
module tb_arith_op_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sw  = '0;
  logic [3:0]  btn = '0;
  logic [11:0] bcd;
  logic        neg, ovf, busy, done;
  logic [7:0]  bb;

  int total = 0;
  int bad   = 0;

  arith_op_sequencer_if #(.WIDTH(8)) dif ();

  // External combinational add/subtract datapath.
  assign bb          = dif.dp_sub ? ~dif.dp_b : dif.dp_b;
  assign dif.dp_sum  = dif.dp_a + bb + {7'd0, dif.dp_sub};
  assign dif.dp_ovf  = (dif.dp_a[7] == bb[7]) && (dif.dp_sum[7] != dif.dp_a[7]);

  arith_op_sequencer #(.DEBOUNCE_CYCLES(4), .WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .dp   (dif.master),
    .sw   (sw),
    .btn  (btn),
    .bcd  (bcd),
    .neg  (neg),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int b, input logic [7:0] v);
    @(negedge clk);
    sw     = v;
    btn[b] = 1'b1;
    tick(10);
    btn[b] = 1'b0;
    tick(12);
    if (b == 0) chk("load_a", dif.dp_a, v);
    else        chk("load_b", dif.dp_b, v);
  endtask

  task automatic do_run(input int b, input bit poke, input logic [11:0] e_bcd,
                        input logic e_neg, input logic e_ovf, input string tag);
    logic [11:0] prev;
    int t, nbusy, extra;
    bit got, hold_ok;
    prev = bcd; hold_ok = 1'b1; nbusy = 0; got = 1'b0; t = 0; extra = 0;
    @(negedge clk);
    btn[b] = 1'b1;
    while (!got && t < 100) begin
      @(negedge clk);
      t++;
      if (t == 10) btn[b] = 1'b0;
      if (busy) begin
        if (poke && nbusy == 0) btn[3] = 1'b1;
        nbusy++;
        if (bcd !== prev) hold_ok = 1'b0;
      end
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_busy_cycles"}, nbusy, 9);
    chk({tag, "_bcd_hold"}, hold_ok, 1);
    chk({tag, "_bcd"}, bcd, e_bcd);
    chk({tag, "_neg"}, neg, e_neg);
    chk({tag, "_ovf"}, ovf, e_ovf);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    btn = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    if (poke) chk({tag, "_no_rerun"}, extra, 0);
  endtask

  initial begin
    int seen, w;

    // Reset state
    tick(3);
    chk("reset_outputs", {dif.dp_a, dif.dp_b, dif.dp_sub, bcd, neg, ovf, busy, done}, 64'd0);
    rst = 1'b1;
    tick(3);

    // 20 + 5 = 25
    load(0, 8'd20);
    load(1, 8'd5);
    do_run(2, 1'b0, 12'h025, 1'b0, 1'b0, "add_20_5");

    // 5 - 20 = -15
    load(0, 8'd5);
    load(1, 8'd20);
    do_run(3, 1'b0, 12'h015, 1'b1, 1'b0, "sub_5_20");

    // 100 + 100 = 0xC8, overflow, shown as -56
    load(0, 8'd100);
    load(1, 8'd100);
    do_run(2, 1'b0, 12'h056, 1'b1, 1'b1, "add_100_100");

    // 0x80 + 0 -> magnitude 128
    load(0, 8'h80);
    load(1, 8'h00);
    do_run(2, 1'b0, 12'h128, 1'b1, 1'b0, "add_80_0");

    // 0x7F - 0x80 = 0xFF, overflow
    load(0, 8'h7F);
    load(1, 8'h80);
    do_run(3, 1'b0, 12'h001, 1'b1, 1'b1, "sub_7f_80");

    // Short glitches on btn[2] must not start a run
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      btn[2] = (k % 3 == 0);
      if (busy || done) seen++;
    end
    btn[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("glitch_no_run", seen, 0);

    // 0x7F + 0x80 = 0xFF, no overflow; subtract press during CONV dropped
    load(0, 8'h7F);
    do_run(2, 1'b1, 12'h001, 1'b1, 1'b0, "add_poke");

    // Reset in the middle of conversion
    @(negedge clk);
    btn[2] = 1'b1;
    w = 0;
    while (!busy && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("rst_run_started", busy, 1);
    tick(5);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", {dif.dp_a, dif.dp_b, dif.dp_sub, bcd, neg, ovf, busy, done}, 64'd0);
    btn = '0;
    tick(3);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("rst_no_done", seen, 0);

    // Fresh run after reset
    load(0, 8'd20);
    load(1, 8'd5);
    do_run(2, 1'b0, 12'h025, 1'b0, 1'b0, "post_rst_add");
`ifdef RESULT_CHAIN_EN
    chk("dp_a_chained", dif.dp_a, 8'd25);
    load(0, 8'd10);
    load(1, 8'd3);
    do_run(2, 1'b0, 12'h013, 1'b0, 1'b0, "chain_1");
    do_run(2, 1'b0, 12'h016, 1'b0, 1'b0, "chain_2");
`else
    chk("dp_a_held", dif.dp_a, 8'd20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
